// File: rtl/sisc_pkg.sv
// Shared definitions for the instruction fetch path.
// The fetch_queue optional HALT-stop behaviour is controlled by the macro FQ_HALT_STOP_EN.
package sisc_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 16;

    // Opcode field position within an instruction word.
    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 28;
    localparam int unsigned OP_W   = OP_MSB - OP_LSB + 1;

    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    // One buffered fetch: instruction word plus the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fq_entry_t;

    // True when the instruction word carries the HALT opcode.
    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[OP_MSB:OP_LSB] == OP_HALT;
    endfunction

endpackage

// File: rtl/fq_ring.sv
// DEPTH-entry circular buffer of fetch entries with write/read pointers and occupancy count.
// clr_i empties the ring and rewinds both pointers; it takes priority over enq_i/deq_i.
module fq_ring
    import sisc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_f,
    input  logic      clr_i,
    input  logic      enq_i,
    input  logic      deq_i,
    input  fq_entry_t wr_entry_i,
    output fq_entry_t rd_entry_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fq_entry_t          entry_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Next pointer/count values; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq_i) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (deq_i) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            case ({enq_i, deq_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed through the count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (enq_i && !clr_i && !rst_f) begin
            entry_q[wptr_q] <= wr_entry_i;
        end
    end

    assign rd_entry_o = entry_q[rptr_q];
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding the instruction register.
// Drives the instruction-memory address, buffers fetched words with their PCs, and
// restarts at flush_addr on a redirect. Define FQ_HALT_STOP_EN to stop fetching after
// a HALT opcode has been enqueued (until the next flush or reset).
module fetch_queue
    import sisc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_f,
    output logic [ADDR_W-1:0]  im_addr,
    input  logic [INSTR_W-1:0] im_data,
    input  logic               deq,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_addr,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               full
);

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic              enq_c;
    logic              deq_c;
    logic              stop_c;
    logic              empty;
    logic              ring_full;
    fq_entry_t         wr_entry;
    fq_entry_t         rd_entry;

`ifdef FQ_HALT_STOP_EN
    logic halt_q, halt_d;

    // Halt latch: set when a HALT word is enqueued, cleared by a redirect.
    always_comb begin
        halt_d = halt_q;
        if (flush) begin
            halt_d = 1'b0;
        end else if (enq_c && is_halt(im_data)) begin
            halt_d = 1'b1;
        end
    end

    // Halt register.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign stop_c = halt_q;
`else
    assign stop_c = 1'b0;
`endif

    // A slot frees up this cycle if the head is being consumed, so a full queue keeps streaming.
    assign deq_c = deq && !empty && !flush;
    assign enq_c = !flush && !stop_c && (!ring_full || (deq && !empty));

    assign wr_entry.instr = im_data;
    assign wr_entry.pc    = fpc_q;

    // Fetch pointer: redirect wins, otherwise advance on every accepted word.
    always_comb begin
        fpc_d = fpc_q;
        if (flush) begin
            fpc_d = flush_addr;
        end else if (enq_c) begin
            fpc_d = fpc_q + ADDR_W'(1);
        end
    end

    // Fetch pointer register.
    always_ff @(posedge clk) begin
        if (rst_f) begin
            fpc_q <= '0;
        end else begin
            fpc_q <= fpc_d;
        end
    end

    fq_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk        (clk),
        .rst_f      (rst_f),
        .clr_i      (flush),
        .enq_i      (enq_c),
        .deq_i      (deq_c),
        .wr_entry_i (wr_entry),
        .rd_entry_o (rd_entry),
        .empty_o    (empty),
        .full_o     (ring_full)
    );

    assign im_addr     = fpc_q;
    assign instr_valid = !empty;
    assign full        = ring_full;
    assign instr_out   = empty ? '0 : rd_entry.instr;
    assign instr_pc    = empty ? '0 : rd_entry.pc;

endmodule
